// File: rtl/io_sequencer.sv
// io_sequencer: multi-cycle controller for the IN, OUT and HALT instructions.
//   Stalls the PC while an IN waits for an operator Set press, captures the switch
//   bank onto the write-back path, latches OUT data for the display and parks the
//   core on HALT until Set is pressed.
//
// Optional feature: define IO_TIMEOUT_EN to give WAIT_IN a timeout of TIMEOUT_CYCLES
//   cycles. On expiry DataIO is cleared and the sticky Timeout flag is raised.
//   Without it, WAIT_IN waits indefinitely and Timeout is tied low.
//
// Ports:
//   Clock        in   system clock (divided processor clock)
//   Reset        in   synchronous, active-high reset
//   IoReq        in   current instruction is IN or OUT (level)
//   IoDir        in   0 = IN, 1 = OUT
//   Halt         in   current instruction is HALT (level)
//   Set          in   debounced operator button (level)
//   Switches     in   operator input value
//   OutData      in   register-file read data for OUT
//   BlockSystem  out  PC/write stall, combinational from state and inputs
//   DataIO       out  captured switch value (registered)
//   Output       out  latched OUT value (registered)
//   OutValid     out  one-cycle pulse when Output is updated
//   WaitingInput out  high in WAIT_IN
//   Halted       out  high in HALTED
//   Timeout      out  sticky timeout flag
module io_sequencer #(
   parameter int unsigned SW_WIDTH        = 13,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned OUT_HOLD_CYCLES = 2,
   parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  IoReq,
   input  logic                  IoDir,
   input  logic                  Halt,
   input  logic                  Set,
   input  logic [SW_WIDTH-1:0]   Switches,
   input  logic [DATA_WIDTH-1:0] OutData,
   output logic                  BlockSystem,
   output logic [DATA_WIDTH-1:0] DataIO,
   output logic [DATA_WIDTH-1:0] Output,
   output logic                  OutValid,
   output logic                  WaitingInput,
   output logic                  Halted,
   output logic                  Timeout
);

   typedef enum logic [2:0] {
      StIdle,
      StWaitIn,
      StRelease,
      StOutHold,
      StHalted
   } state_e;

   // The detect cycle counts as the first OUT cycle, so the hold counter starts one lower.
   localparam bit        HoldEn   = (OUT_HOLD_CYCLES != 0);
   localparam logic [7:0] HoldInit = HoldEn ? 8'(OUT_HOLD_CYCLES - 1) : 8'd0;

   state_e                state_q, state_d;
   logic                  set_q;
   logic                  set_rise;
   logic [7:0]            hold_q, hold_d;
   logic [DATA_WIDTH-1:0] data_io_q, data_io_d;
   logic [DATA_WIDTH-1:0] output_q, output_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] sw_ext;

`ifdef IO_TIMEOUT_EN
   localparam logic [31:0] ToLast = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0] to_cnt_q, to_cnt_d;
   logic        timeout_q, timeout_d;
`endif

   // set_q resets high so a button already held through reset is not seen as a press.
   assign set_rise = Set & ~set_q;

   always_comb begin
      sw_ext                = '0;
      sw_ext[SW_WIDTH-1:0]  = Switches;
   end

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      data_io_d    = data_io_q;
      output_d     = output_q;
      out_valid_d  = 1'b0;
      BlockSystem  = 1'b0;
      WaitingInput = 1'b0;
      Halted       = 1'b0;
`ifdef IO_TIMEOUT_EN
      to_cnt_d     = to_cnt_q;
      timeout_d    = timeout_q;
`endif

      case (state_q)
         StIdle: begin
            // Set edges here are dropped: an IN always needs a fresh press in WAIT_IN.
            if (Halt) begin
               BlockSystem = 1'b1;
               state_d     = StHalted;
            end else if (IoReq && !IoDir) begin
               BlockSystem = 1'b1;
               state_d     = StWaitIn;
`ifdef IO_TIMEOUT_EN
               to_cnt_d    = '0;
               timeout_d   = 1'b0;
`endif
            end else if (IoReq && IoDir) begin
               output_d    = OutData;
               out_valid_d = 1'b1;
               if (HoldEn) begin
                  BlockSystem = 1'b1;
                  hold_d      = HoldInit;
                  state_d     = StOutHold;
               end
            end
         end

         StWaitIn: begin
            BlockSystem  = 1'b1;
            WaitingInput = 1'b1;
            if (set_rise) begin
               data_io_d = sw_ext;
               state_d   = StRelease;
            end
`ifdef IO_TIMEOUT_EN
            else if (to_cnt_q == ToLast) begin
               data_io_d = '0;
               timeout_d = 1'b1;
               state_d   = StRelease;
            end else begin
               to_cnt_d = to_cnt_q + 32'd1;
            end
`endif
         end

         // One unstalled cycle lets the PC advance and the register file take DataIO.
         StRelease: begin
            state_d = StIdle;
         end

         StOutHold: begin
            if (hold_q != 8'd0) begin
               BlockSystem = 1'b1;
               hold_d      = hold_q - 8'd1;
            end else begin
               state_d = StIdle;
            end
         end

         StHalted: begin
            BlockSystem = 1'b1;
            Halted      = 1'b1;
            if (set_rise) begin
               state_d = StRelease;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= StIdle;
         set_q       <= 1'b1;
         hold_q      <= '0;
         data_io_q   <= '0;
         output_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         set_q       <= Set;
         hold_q      <= hold_d;
         data_io_q   <= data_io_d;
         output_q    <= output_d;
         out_valid_q <= out_valid_d;
      end
   end

`ifdef IO_TIMEOUT_EN
   always_ff @(posedge Clock) begin
      if (Reset) begin
         to_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         to_cnt_q  <= to_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign Timeout = timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign Timeout            = 1'b0;
`endif

   assign DataIO   = data_io_q;
   assign Output   = output_q;
   assign OutValid = out_valid_q;

endmodule

// File: tb/tb_io_sequencer.sv
// Bench for io_sequencer: a per-cycle vector table driven through a scoreboard queue,
// checked against a default instance (OUT_HOLD_CYCLES = 2) and a single-cycle OUT
// instance (OUT_HOLD_CYCLES = 0). With IO_TIMEOUT_EN a third instance with an
// 8-cycle timeout is exercised by a hand-written sequence.
module tb_io_sequencer;

   logic        Clock = 1'b0;
   logic        Reset, IoReq, IoDir, Halt, Set;
   logic [12:0] Switches;
   logic [31:0] OutData;

   logic        bs, ov, wt, hl, to;
   logic [31:0] dio, outv;
   logic        bs0, ov0, wt0, hl0, to0;
   logic [31:0] dio0, outv0;

   int checks = 0;
   int errors = 0;

   always #5 Clock = ~Clock;

   io_sequencer #(.SW_WIDTH(13), .DATA_WIDTH(32), .OUT_HOLD_CYCLES(2), .TIMEOUT_CYCLES(1000))
   dut (
      .Clock(Clock), .Reset(Reset), .IoReq(IoReq), .IoDir(IoDir), .Halt(Halt), .Set(Set),
      .Switches(Switches), .OutData(OutData), .BlockSystem(bs), .DataIO(dio), .Output(outv),
      .OutValid(ov), .WaitingInput(wt), .Halted(hl), .Timeout(to)
   );

   io_sequencer #(.SW_WIDTH(13), .DATA_WIDTH(32), .OUT_HOLD_CYCLES(0), .TIMEOUT_CYCLES(1000))
   dut0 (
      .Clock(Clock), .Reset(Reset), .IoReq(IoReq), .IoDir(IoDir), .Halt(Halt), .Set(Set),
      .Switches(Switches), .OutData(OutData), .BlockSystem(bs0), .DataIO(dio0), .Output(outv0),
      .OutValid(ov0), .WaitingInput(wt0), .Halted(hl0), .Timeout(to0)
   );

`ifdef IO_TIMEOUT_EN
   logic        bst, ovt, wtt, hlt, tot;
   logic [31:0] diot, outvt;

   io_sequencer #(.SW_WIDTH(13), .DATA_WIDTH(32), .OUT_HOLD_CYCLES(2), .TIMEOUT_CYCLES(8))
   dut_to (
      .Clock(Clock), .Reset(Reset), .IoReq(IoReq), .IoDir(IoDir), .Halt(Halt), .Set(Set),
      .Switches(Switches), .OutData(OutData), .BlockSystem(bst), .DataIO(diot), .Output(outvt),
      .OutValid(ovt), .WaitingInput(wtt), .Halted(hlt), .Timeout(tot)
   );
`endif

   typedef struct {
      logic        rst, req, dir, halt, set;
      logic [12:0] sw;
      logic [31:0] od;
      int          reps;
      logic        bs, bs0;
      logic [31:0] dio, outv;
      logic        ov, wt, hl;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];

   task automatic add(input logic rst, req, dir, halt, set, input logic [12:0] sw,
                      input logic [31:0] od, input int reps, input logic e_bs, e_bs0,
                      input logic [31:0] e_dio, e_out, input logic e_ov, e_wt, e_hl);
      vec_t v;
      v.rst = rst; v.req = req; v.dir = dir; v.halt = halt; v.set = set;
      v.sw = sw; v.od = od; v.reps = reps;
      v.bs = e_bs; v.bs0 = e_bs0; v.dio = e_dio; v.outv = e_out;
      v.ov = e_ov; v.wt = e_wt; v.hl = e_hl;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Inputs change just after the rising edge; outputs are sampled on the falling edge.
   task automatic drive(input logic rst, req, dir, halt, set, input logic [12:0] sw,
                        input logic [31:0] od);
      @(posedge Clock);
      #1;
      Reset = rst; IoReq = req; IoDir = dir; Halt = halt; Set = set;
      Switches = sw; OutData = od;
   endtask

   initial begin
      vec_t v, e;
      int   row;

      Reset = 1'b1; IoReq = 1'b0; IoDir = 1'b0; Halt = 1'b0; Set = 1'b1;
      Switches = '0; OutData = '0;
      repeat (2) @(posedge Clock);

      // rst req dir halt set sw od reps | bs bs0 dio out ov wt hl
      // Reset state, then Set held high through reset and the IN request
      add(1, 0, 0, 0, 1, 0, 0, 1,            0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 1, 0, 0, 1,            1, 1, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 2,            1, 1, 0, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1,            1, 1, 0, 0, 0, 1, 0);
      add(0, 0, 0, 0, 1, 13'h0AB, 0, 1,      1, 1, 0, 0, 0, 1, 0);
      add(0, 0, 0, 0, 1, 0, 0, 1,            0, 0, 32'hAB, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1,            0, 0, 32'hAB, 0, 0, 0, 0);
      // IN flow: 10 idle cycles in WAIT_IN then a press with 0x1A5
      add(0, 1, 0, 0, 0, 0, 0, 1,            1, 1, 32'hAB, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 10,           1, 1, 32'hAB, 0, 0, 1, 0);
      add(0, 0, 0, 0, 1, 13'h1A5, 0, 1,      1, 1, 32'hAB, 0, 0, 1, 0);
      add(0, 0, 0, 0, 1, 0, 0, 1,            0, 0, 32'h1A5, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1,            0, 0, 32'h1A5, 0, 0, 0, 0);
      // Press coinciding with the IN detect cycle is ignored
      add(0, 1, 0, 0, 1, 0, 0, 1,            1, 1, 32'h1A5, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 13'h111, 0, 1,      1, 1, 32'h1A5, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1,            1, 1, 32'h1A5, 0, 0, 1, 0);
      add(0, 0, 0, 0, 1, 13'h1FFF, 0, 1,     1, 1, 32'h1A5, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1,            0, 0, 32'h1FFF, 0, 0, 0, 0);
      // Press in IDLE with no request is discarded
      add(0, 0, 0, 0, 1, 0, 0, 1,            0, 0, 32'h1FFF, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1,            0, 0, 32'h1FFF, 0, 0, 0, 0);
      // OUT flow, twice back to back
      add(0, 1, 1, 0, 0, 0, 32'hDEADBEEF, 1, 1, 0, 32'h1FFF, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1,            1, 0, 32'h1FFF, 32'hDEADBEEF, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1,            0, 0, 32'h1FFF, 32'hDEADBEEF, 0, 0, 0);
      add(0, 1, 1, 0, 0, 0, 32'h12345678, 1, 1, 0, 32'h1FFF, 32'hDEADBEEF, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1,            1, 0, 32'h1FFF, 32'h12345678, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1,            0, 0, 32'h1FFF, 32'h12345678, 0, 0, 0);
      // Halt beats IoReq; requests ignored while halted; Set resumes via RELEASE
      add(0, 1, 1, 1, 0, 0, 32'hCAFE, 1,     1, 1, 32'h1FFF, 32'h12345678, 0, 0, 0);
      add(0, 1, 1, 0, 0, 0, 32'h0BADF00D, 2, 1, 1, 32'h1FFF, 32'h12345678, 0, 0, 1);
      add(0, 0, 0, 0, 1, 0, 0, 1,            1, 1, 32'h1FFF, 32'h12345678, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0, 1,            0, 0, 32'h1FFF, 32'h12345678, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1,            0, 0, 32'h1FFF, 32'h12345678, 0, 0, 0);
      // Reset in WAIT_IN
      add(0, 1, 0, 0, 0, 0, 0, 1,            1, 1, 32'h1FFF, 32'h12345678, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1,            1, 1, 32'h1FFF, 32'h12345678, 0, 1, 0);
      add(1, 0, 0, 0, 0, 0, 0, 1,            1, 1, 32'h1FFF, 32'h12345678, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1,            0, 0, 0, 0, 0, 0, 0);
      // Reset in OUT_HOLD
      add(0, 1, 1, 0, 0, 0, 32'h55AA, 1,     1, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 1,            1, 0, 0, 32'h55AA, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1,            0, 0, 0, 0, 0, 0, 0);

      row = 0;
      foreach (vecs[i]) begin
         v = vecs[i];
         for (int r = 0; r < v.reps; r++) begin
            drive(v.rst, v.req, v.dir, v.halt, v.set, v.sw, v.od);
            exp_q.push_back(v);
            @(negedge Clock);
            e = exp_q.pop_front();
            chk($sformatf("row%0d.%0d BlockSystem", i, r), 32'(bs), 32'(e.bs));
            chk($sformatf("row%0d.%0d BlockSystem(hold0)", i, r), 32'(bs0), 32'(e.bs0));
            chk($sformatf("row%0d.%0d DataIO", i, r), dio, e.dio);
            chk($sformatf("row%0d.%0d Output", i, r), outv, e.outv);
            chk($sformatf("row%0d.%0d Output(hold0)", i, r), outv0, e.outv);
            chk($sformatf("row%0d.%0d OutValid", i, r), 32'(ov), 32'(e.ov));
            chk($sformatf("row%0d.%0d OutValid(hold0)", i, r), 32'(ov0), 32'(e.ov));
            chk($sformatf("row%0d.%0d WaitingInput", i, r), 32'(wt), 32'(e.wt));
            chk($sformatf("row%0d.%0d Halted", i, r), 32'(hl), 32'(e.hl));
            chk($sformatf("row%0d.%0d Timeout", i, r), 32'(to), 32'(0));
            row++;
         end
      end

`ifdef IO_TIMEOUT_EN
      // Capture 0x0F0F so the timeout's clearing of DataIO is visible
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 13'h0F0F, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge Clock);
      chk("to capture DataIO", diot, 32'h0F0F);
      drive(0, 0, 0, 0, 0, 0, 0);
      // IN with no press: 8 WAIT_IN cycles then timeout
      drive(0, 1, 0, 0, 0, 0, 0);
      @(negedge Clock);
      chk("to detect BlockSystem", 32'(bst), 32'(1));
      for (int k = 0; k < 8; k++) begin
         drive(0, 0, 0, 0, 0, 0, 0);
         @(negedge Clock);
         chk($sformatf("to wait%0d WaitingInput", k), 32'(wtt), 32'(1));
         chk($sformatf("to wait%0d Timeout", k), 32'(tot), 32'(0));
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge Clock);
      chk("to expire BlockSystem", 32'(bst), 32'(0));
      chk("to expire DataIO", diot, 32'h0);
      chk("to expire Timeout", 32'(tot), 32'(1));
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge Clock);
      chk("to idle Timeout sticky", 32'(tot), 32'(1));
      chk("to idle WaitingInput", 32'(wtt), 32'(0));
      drive(0, 1, 0, 0, 0, 0, 0);
      @(negedge Clock);
      chk("to re-detect Timeout", 32'(tot), 32'(1));
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge Clock);
      chk("to re-entry Timeout cleared", 32'(tot), 32'(0));
      repeat (6) drive(0, 0, 0, 0, 0, 0, 0);
      // Press on the expiry cycle wins
      drive(0, 0, 0, 0, 1, 13'h123, 0);
      @(negedge Clock);
      chk("to race WaitingInput", 32'(wtt), 32'(1));
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge Clock);
      chk("to race DataIO", diot, 32'h123);
      chk("to race Timeout", 32'(tot), 32'(0));
      chk("to race BlockSystem", 32'(bst), 32'(0));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
